// File: rtl/flappy_pkg.sv
// Shared types and helpers for the LED-matrix bird game controller.
package flappy_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HIT  = 2'd2,
        OVER = 2'd3
    } game_state_e;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_NINE = 4'd9;

    // Counter width for a modulo-n counter, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/flappy_game_ctrl_bcd_counter.sv
// Multi-digit BCD up-counter with synchronous clear; saturates at all nines.
module bcd_counter
    import flappy_pkg::*;
#(
    parameter int DIGITS = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                inc,
    output logic [4*DIGITS-1:0] q
);

    logic [4*DIGITS-1:0] q_inc;
    logic                all_nines;

    // Ripple-carry BCD increment and all-nines detection.
    always_comb begin
        bcd_t digit;
        logic carry;
        q_inc     = q;
        carry     = 1'b1;
        all_nines = 1'b1;
        digit     = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            digit = q[4*i +: 4];
            if (digit != BCD_NINE) begin
                all_nines = 1'b0;
            end
            if (carry) begin
                if (digit == BCD_NINE) begin
                    q_inc[4*i +: 4] = '0;
                end else begin
                    q_inc[4*i +: 4] = digit + 4'd1;
                    carry           = 1'b0;
                end
            end
        end
    end

    // Score register: clear wins, increment is dropped once saturated.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (inc && !all_nines) begin
            q <= q_inc;
        end
    end

endmodule

// File: rtl/flappy_game_ctrl.sv
// Game controller: FSM, bird fall/flap physics, collision, BCD score and speed level.
module flappy_game_ctrl
    import flappy_pkg::*;
#(
    parameter int ROWS       = 16,
    parameter int DIGITS     = 6,
    parameter int FALL_DIV   = 4,
    parameter int FLAP_ROWS  = 2,
    parameter int HIT_TICKS  = 8,
    parameter int LEVEL_STEP = 5,
    parameter int MAX_LEVEL  = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             tick,
    input  logic                             flap,
    input  logic                             start,
    input  logic [ROWS-1:0]                  obstacle_col,
    input  logic                             pipe_pass,
    output logic [$clog2(ROWS)-1:0]          bird_row,
    output logic [ROWS-1:0]                  bird_onehot,
    output logic [1:0]                       state,
    output logic [4*DIGITS-1:0]              score_bcd,
    output logic [$clog2(MAX_LEVEL+1)-1:0]   level,
    output logic                             game_over
);

    localparam int RW = $clog2(ROWS);
    localparam int LW = $clog2(MAX_LEVEL + 1);
    localparam int FW = cnt_width(FALL_DIV);
    localparam int HW = cnt_width(HIT_TICKS);
    localparam int PW = cnt_width(LEVEL_STEP);

    localparam logic [RW-1:0] ROW_MID   = RW'(ROWS / 2);
    localparam logic [RW-1:0] ROW_FLOOR = RW'(ROWS - 1);

    game_state_e state_q, state_d;

    logic [FW-1:0]   fall_cnt, fall_cnt_d;
    logic [HW-1:0]   hit_cnt, hit_cnt_d;
    logic [PW-1:0]   pass_cnt, pass_cnt_d;
    logic            blank, blank_d;
    logic [RW-1:0]   bird_row_d;
    logic [ROWS-1:0] bird_onehot_d;
    logic [LW-1:0]   level_d;
    logic            game_over_d;
    logic            collision;
    logic            score_clr;
    logic            score_inc;

    assign collision = (state_q == PLAY) &&
                       (obstacle_col[bird_row] || (bird_row == ROW_FLOOR));

    assign state = state_q;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = PLAY;
            PLAY: if (collision) state_d = HIT;
            HIT:  if (tick && (hit_cnt == HW'(HIT_TICKS - 1))) state_d = OVER;
            OVER: if (start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for the registered outputs and internal counters.
    // A collision cycle freezes the bird and drops any pipe_pass seen alongside it.
    always_comb begin
        bird_row_d = bird_row;
        fall_cnt_d = fall_cnt;
        hit_cnt_d  = hit_cnt;
        pass_cnt_d = pass_cnt;
        level_d    = level;
        blank_d    = blank;
        score_clr  = 1'b0;
        score_inc  = 1'b0;
        unique case (state_q)
            IDLE: begin
                bird_row_d = ROW_MID;
                fall_cnt_d = '0;
                hit_cnt_d  = '0;
                blank_d    = 1'b0;
                if (start) begin
                    pass_cnt_d = '0;
                    level_d    = '0;
                    score_clr  = 1'b1;
                end
            end
            PLAY: begin
                if (!collision) begin
                    if (flap) begin
                        bird_row_d = (int'(bird_row) >= FLAP_ROWS) ?
                                     bird_row - RW'(FLAP_ROWS) : '0;
                        fall_cnt_d = '0;
                    end else if (tick) begin
                        if (fall_cnt == FW'(FALL_DIV - 1)) begin
                            fall_cnt_d = '0;
                            if (bird_row != ROW_FLOOR) begin
                                bird_row_d = bird_row + 1'b1;
                            end
                        end else begin
                            fall_cnt_d = fall_cnt + 1'b1;
                        end
                    end
                    if (pipe_pass) begin
                        score_inc = 1'b1;
                        if (pass_cnt == PW'(LEVEL_STEP - 1)) begin
                            pass_cnt_d = '0;
                            if (level != LW'(MAX_LEVEL)) begin
                                level_d = level + 1'b1;
                            end
                        end else begin
                            pass_cnt_d = pass_cnt + 1'b1;
                        end
                    end
                end
            end
            HIT: begin
                if (tick) begin
                    if (hit_cnt == HW'(HIT_TICKS - 1)) begin
                        hit_cnt_d = '0;
                        blank_d   = 1'b0;
                    end else begin
                        hit_cnt_d = hit_cnt + 1'b1;
                        blank_d   = ~blank;
                    end
                end
            end
            OVER: begin
                if (start) begin
                    bird_row_d = ROW_MID;
                    fall_cnt_d = '0;
                end
            end
            default: ;
        endcase
        bird_onehot_d = blank_d ? '0 : (ROWS'(1) << bird_row_d);
        game_over_d   = (state_d == OVER);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bird_row    <= ROW_MID;
            bird_onehot <= ROWS'(1) << ROW_MID;
            fall_cnt    <= '0;
            hit_cnt     <= '0;
            pass_cnt    <= '0;
            level       <= '0;
            blank       <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            bird_row    <= bird_row_d;
            bird_onehot <= bird_onehot_d;
            fall_cnt    <= fall_cnt_d;
            hit_cnt     <= hit_cnt_d;
            pass_cnt    <= pass_cnt_d;
            level       <= level_d;
            blank       <= blank_d;
            game_over   <= game_over_d;
        end
    end

    bcd_counter #(
        .DIGITS(DIGITS)
    ) u_score (
        .clk   (clk),
        .reset (reset),
        .clear (score_clr),
        .inc   (score_inc),
        .q     (score_bcd)
    );

endmodule
